// File: rtl/Purple_Jade_pkg.sv
// Shared types for the immediate-generation stage: extension formats and the output entry record.
package Purple_Jade_pkg;

  localparam int IMM_FMT_WIDTH = 3;
  localparam int IMM_WORD_W    = 16;
  localparam int IMM_TAG_W     = 16;

  typedef enum logic [IMM_FMT_WIDTH-1:0] {
    IMM_8Z  = 3'd0,
    IMM_3Z  = 3'd1,
    IMM_7Z  = 3'd2,
    IMM_5Z  = 3'd3,
    IMM_8S  = 3'd4,
    IMM_11S = 3'd5,
    IMM_6S  = 3'd6,
    REG_4Z  = 3'd7
  } imm_fmt_e;

  // Default-width entry record; the stage builds its own copy sized by its parameters.
  typedef struct packed {
    logic [IMM_WORD_W-1:0] immediate;
    logic [IMM_TAG_W-1:0]  tag;
    logic                  pfx_used;
  } imm_entry_s;

endpackage

// File: rtl/imm_format_mux.sv
// Selects and extends the immediate field of an instruction by format. Combinational, no backpressure.
module imm_format_mux
  import Purple_Jade_pkg::*;
#(
  parameter int WORD_SIZE_P = 16
) (
  input  logic [WORD_SIZE_P-1:0] instr_i,
  input  imm_fmt_e               fmt_i,
  output logic [WORD_SIZE_P-1:0] ext_o
);
  logic [WORD_SIZE_P-1:0] z8, z3, z7, z5, s8, s11, s6, z4;

  zero_extend #(.IN_W_P(8),  .OUT_W_P(WORD_SIZE_P)) u_z8  (.data_i(instr_i[7:0]),  .data_o(z8));
  zero_extend #(.IN_W_P(3),  .OUT_W_P(WORD_SIZE_P)) u_z3  (.data_i(instr_i[8:6]),  .data_o(z3));
  zero_extend #(.IN_W_P(7),  .OUT_W_P(WORD_SIZE_P)) u_z7  (.data_i(instr_i[12:6]), .data_o(z7));
  zero_extend #(.IN_W_P(5),  .OUT_W_P(WORD_SIZE_P)) u_z5  (.data_i(instr_i[10:6]), .data_o(z5));
  sign_extend #(.IN_W_P(8),  .OUT_W_P(WORD_SIZE_P)) u_s8  (.data_i(instr_i[7:0]),  .data_o(s8));
  sign_extend #(.IN_W_P(11), .OUT_W_P(WORD_SIZE_P)) u_s11 (.data_i(instr_i[10:0]), .data_o(s11));
  sign_extend #(.IN_W_P(6),  .OUT_W_P(WORD_SIZE_P)) u_s6  (.data_i(instr_i[5:0]),  .data_o(s6));
  zero_extend #(.IN_W_P(4),  .OUT_W_P(WORD_SIZE_P)) u_z4  (.data_i(instr_i[6:3]),  .data_o(z4));

  // No format reads the bits above 12.
  logic unused_hi;
  assign unused_hi = ^instr_i[WORD_SIZE_P-1:13];

  always_comb begin
    ext_o = '0;
    case (fmt_i)
      IMM_8Z:  ext_o = z8;
      IMM_3Z:  ext_o = z3;
      IMM_7Z:  ext_o = z7;
      IMM_5Z:  ext_o = z5;
      IMM_8S:  ext_o = s8;
      IMM_11S: ext_o = s11;
      IMM_6S:  ext_o = s6;
      REG_4Z:  ext_o = z4;
      default: ext_o = '0;
    endcase
  end
endmodule

// File: rtl/sign_extend.sv
// Sign-extends an IN_W_P-bit field to OUT_W_P bits. Combinational, no backpressure.
module sign_extend #(
  parameter int IN_W_P  = 8,
  parameter int OUT_W_P = 16
) (
  input  logic [IN_W_P-1:0]  data_i,
  output logic [OUT_W_P-1:0] data_o
);
  assign data_o = {{(OUT_W_P-IN_W_P){data_i[IN_W_P-1]}}, data_i};
endmodule

// File: rtl/zero_extend.sv
// Zero-extends an IN_W_P-bit field to OUT_W_P bits. Combinational, no backpressure.
module zero_extend #(
  parameter int IN_W_P  = 8,
  parameter int OUT_W_P = 16
) (
  input  logic [IN_W_P-1:0]  data_i,
  output logic [OUT_W_P-1:0] data_o
);
  assign data_o = {{(OUT_W_P-IN_W_P){1'b0}}, data_i};
endmodule

// File: rtl/imm_gen_stage.sv
// Formats instructions into immediates (with optional prefix for the upper bits) into a DEPTH_P FIFO; 1-cycle latency.
// valid/ready both sides; ready_o = !full from registered state only; flush_i drops the queue and any pending prefix.
module imm_gen_stage
  import Purple_Jade_pkg::*;
#(
  parameter int WORD_SIZE_P   = 16,
  parameter int PREFIX_BITS_P = 11,
  parameter int DEPTH_P       = 2,
  parameter int TAG_WIDTH_P   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [WORD_SIZE_P-1:0]   instr_i,
  input  logic [IMM_FMT_WIDTH-1:0] fmt_i,
  input  logic                     prefix_i,
  input  logic [TAG_WIDTH_P-1:0]   tag_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [WORD_SIZE_P-1:0]   immediate_o,
  output logic [TAG_WIDTH_P-1:0]   tag_o,
  output logic                     pfx_used_o
);
  localparam int LOW_BITS = WORD_SIZE_P - PREFIX_BITS_P;
  localparam int PTR_W    = $clog2(DEPTH_P);
  localparam int CNT_W    = PTR_W + 1;

  typedef struct packed {
    logic [WORD_SIZE_P-1:0] immediate;
    logic [TAG_WIDTH_P-1:0] tag;
    logic                   pfx_used;
  } entry_t;

  entry_t                   mem_q [DEPTH_P];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [PREFIX_BITS_P-1:0] pfx_q, pfx_d;
  logic                     pfx_pend_q, pfx_pend_d;

  logic                   full, empty, accept, push, pop;
  logic [WORD_SIZE_P-1:0] ext;
  entry_t                 new_entry, head;

  imm_format_mux #(.WORD_SIZE_P(WORD_SIZE_P)) u_fmt (
    .instr_i (instr_i),
    .fmt_i   (imm_fmt_e'(fmt_i)),
    .ext_o   (ext)
  );

  assign full    = (count_q == CNT_W'(DEPTH_P));
  assign empty   = (count_q == '0);
  assign ready_o = !full;
  assign valid_o = !empty;
  assign accept  = valid_i && ready_o && !flush_i;
  assign push    = accept && !prefix_i;
  assign pop     = valid_o && ready_i && !flush_i;

  always_comb begin
    new_entry.tag      = tag_i;
    new_entry.pfx_used = pfx_pend_q;
    if (pfx_pend_q) new_entry.immediate = {pfx_q, ext[LOW_BITS-1:0]};
    else            new_entry.immediate = ext;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pfx_q_hold: begin end
    pfx_d      = pfx_q;
    pfx_pend_d = pfx_pend_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pfx_pend_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (accept && prefix_i) begin
        pfx_d      = instr_i[PREFIX_BITS_P-1:0];
        pfx_pend_d = 1'b1;
      end else if (push) begin
        pfx_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pfx_q      <= '0;
      pfx_pend_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pfx_q      <= pfx_d;
      pfx_pend_q <= pfx_pend_d;
    end
  end

  // Storage needs no reset: an empty FIFO forces the outputs to zero.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head        = mem_q[rd_ptr_q];
  assign immediate_o = empty ? '0 : head.immediate;
  assign tag_o       = empty ? '0 : head.tag;
  assign pfx_used_o  = empty ? 1'b0 : head.pfx_used;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed vectors with a queue scoreboard; a negedge monitor compares every popped output entry.
module tb_imm_gen_stage;
  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] instr_i = '0;
  logic [2:0]  fmt_i = '0;
  logic        prefix_i = 1'b0;
  logic [15:0] tag_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [15:0] immediate_o;
  logic [15:0] tag_o;
  logic        pfx_used_o;

  typedef struct {
    logic [15:0] imm;
    logic [15:0] tag;
    logic        used;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  imm_gen_stage dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .instr_i(instr_i),
    .fmt_i(fmt_i), .prefix_i(prefix_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .immediate_o(immediate_o),
    .tag_o(tag_o), .pfx_used_o(pfx_used_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every entry the consumer takes must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_n_i && !flush_i && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got imm 0x%0h tag 0x%0h, expected nothing", immediate_o, tag_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_imm", {16'h0, immediate_o}, {16'h0, e.imm});
          chk("out_tag", {16'h0, tag_o}, {16'h0, e.tag});
          chk("out_pfx_used", {31'h0, pfx_used_o}, {31'h0, e.used});
        end
      end
    end
  end

  task automatic beat(input logic pfx, input logic [2:0] fmt, input logic [15:0] instr,
                      input logic [15:0] tag, input logic [15:0] exp_imm, input logic exp_used);
    bit done;
    exp_t e;
    done     = 1'b0;
    valid_i  = 1'b1;
    prefix_i = pfx;
    fmt_i    = fmt;
    instr_i  = instr;
    tag_i    = tag;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_i);
      done = ready_o;
      @(posedge clk_i);
      #1;
    end
    valid_i  = 1'b0;
    prefix_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: instr 0x%0h never accepted, expected acceptance", instr);
    end else if (!pfx) begin
      e.imm  = exp_imm;
      e.tag  = tag;
      e.used = exp_used;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk_i);
    repeat (2) @(posedge clk_i);
    #1;
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_valid_idle"}, {31'h0, valid_o}, 0);
  endtask

  initial begin
    #3;
    chk("rst_valid", {31'h0, valid_o}, 0);
    chk("rst_ready", {31'h0, ready_o}, 1);
    chk("rst_imm", {16'h0, immediate_o}, 0);
    #9 reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Basic formats
    beat(0, 3'd4, 16'h00F0, 16'h0101, 16'hFFF0, 0);
    beat(0, 3'd5, 16'h0400, 16'h0102, 16'hFC00, 0);
    beat(0, 3'd2, 16'h1FC0, 16'h0103, 16'h007F, 0);
    beat(0, 3'd7, 16'h0078, 16'h0104, 16'h000F, 0);
    beat(0, 3'd1, 16'h01C0, 16'h0105, 16'h0007, 0);
    beat(0, 3'd3, 16'h07C0, 16'h0106, 16'h001F, 0);
    beat(0, 3'd6, 16'h0020, 16'h0107, 16'hFFE0, 0);
    beat(0, 3'd0, 16'hAB12, 16'h0108, 16'h0012, 0);
    drain("fmt");

    // Prefix combine, then a plain beat
    beat(1, 3'd3, 16'h07FF, 16'hDEAD, 16'h0, 0);
    beat(0, 3'd0, 16'h0013, 16'h0201, 16'hFFF3, 1);
    beat(0, 3'd0, 16'h0013, 16'h0202, 16'h0013, 0);
    drain("pfx");

    // Second prefix overwrites the first; only one entry results
    beat(1, 3'd0, 16'h0001, 16'h0, 16'h0, 0);
    beat(1, 3'd0, 16'h0002, 16'h0, 16'h0, 0);
    beat(0, 3'd0, 16'h0000, 16'h0301, 16'h0040, 1);
    drain("pfx2");

    // Backpressure: two fill the FIFO, the third is held until ready_i returns
    ready_i = 1'b0;
    beat(0, 3'd0, 16'h0011, 16'h0401, 16'h0011, 0);
    beat(0, 3'd0, 16'h0022, 16'h0402, 16'h0022, 0);
    chk("full_ready", {31'h0, ready_o}, 0);
    chk("full_head_imm", {16'h0, immediate_o}, 16'h0011);
    fork
      beat(0, 3'd0, 16'h0033, 16'h0403, 16'h0033, 0);
      begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("held_ready", {31'h0, ready_o}, 0);
        chk("held_imm_stable", {16'h0, immediate_o}, 16'h0011);
        ready_i = 1'b1;
      end
    join
    drain("bp");

    // Flush drops a queued entry and a pending prefix
    ready_i = 1'b0;
    beat(0, 3'd0, 16'h0044, 16'h0501, 16'h0044, 0);
    beat(1, 3'd0, 16'h07FF, 16'h0, 16'h0, 0);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    exp_q.delete();
    chk("flush_valid", {31'h0, valid_o}, 0);
    ready_i = 1'b1;
    beat(0, 3'd0, 16'h0013, 16'h0502, 16'h0013, 0);
    drain("flush");

    // Asynchronous reset mid-stream
    ready_i = 1'b0;
    beat(1, 3'd0, 16'h07FF, 16'h0, 16'h0, 0);
    beat(0, 3'd0, 16'h0055, 16'h0601, 16'hFFF5, 1);
    beat(0, 3'd0, 16'h0066, 16'h0602, 16'h0066, 0);
    chk("pre_rst_ready", {31'h0, ready_o}, 0);
    #2 reset_n_i = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_valid", {31'h0, valid_o}, 0);
    chk("arst_ready", {31'h0, ready_o}, 1);
    chk("arst_imm", {16'h0, immediate_o}, 0);
    chk("arst_tag", {16'h0, tag_o}, 0);
    chk("arst_pfx_used", {31'h0, pfx_used_o}, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    beat(0, 3'd0, 16'h0005, 16'h0701, 16'h0005, 0);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
